// File: rtl/matrix_keypad_scanner.sv
// Key-matrix scanner: one-hot column strobe, per-column frame capture, whole-frame debounce
// and single-key reporting. Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.

module keypad_col_slot #(
  parameter int N_ROWS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic              commit,
  input  logic [N_ROWS-1:0] row_sense,
  output logic [N_ROWS-1:0] new_rows,
  output logic              same
);
  logic [N_ROWS-1:0] slot_q;
  logic [N_ROWS-1:0] prev_q;

  // The last column's sample is folded in combinationally so the frame compares on its completing edge.
  assign new_rows = capture ? row_sense : slot_q;
  assign same     = (new_rows == prev_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
      prev_q <= '0;
    end else begin
      if (capture) slot_q <= row_sense;
      if (commit)  prev_q <= new_rows;
    end
  end
endmodule

module matrix_keypad_scanner #(
  parameter int N_COLS         = 4,
  parameter int N_ROWS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 50
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_ROWS-1:0]                 row_sense,
  output logic [N_COLS-1:0]                 column_drive,
  output logic [$clog2(N_COLS*N_ROWS)-1:0]  key_code,
  output logic                              key_valid,
  output logic                              key_held,
  output logic                              key_multi
);
  localparam int CW = $clog2(N_COLS*N_ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS+1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV-1);
  localparam logic [SW-1:0] DEB_MAX    = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] DEB_LAST   = SW'(DEBOUNCE_SCANS-1);

  generate
    if (N_COLS < 2 || N_ROWS < 1 || SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1)
    begin : g_bad_param
      $error("matrix_keypad_scanner: parameter out of range");
    end
  endgenerate

  logic [DW-1:0] dwell;
  logic          sample;
  logic          frame_done;

  assign sample     = (dwell == DWELL_LAST);
  assign frame_done = sample & column_drive[N_COLS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell        <= '0;
      column_drive <= N_COLS'(1);
    end else if (sample) begin
      dwell        <= '0;
      column_drive <= {column_drive[N_COLS-2:0], column_drive[N_COLS-1]};
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  logic [N_COLS-1:0][N_ROWS-1:0] new_frame;
  logic [N_COLS-1:0]             lane_same;

  generate
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      keypad_col_slot #(.N_ROWS(N_ROWS)) u_slot (
        .clock     (clock),
        .reset     (reset),
        .capture   (sample & column_drive[c]),
        .commit    (frame_done),
        .row_sense (row_sense),
        .new_rows  (new_frame[c]),
        .same      (lane_same[c])
      );
    end
  endgenerate

  // Saturating key count (0, 1, 2+) and code of the last key seen.
  logic [1:0]    hit_cnt;
  logic [CW-1:0] hit_code;

  always_comb begin
    hit_cnt  = 2'd0;
    hit_code = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (new_frame[c][r]) begin
          if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
          hit_code = CW'(c*N_ROWS + r);
        end
      end
    end
  end

  logic [SW-1:0] stable_cnt;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES+1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_FRAMES-1);
  logic [RW-1:0] rep_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      key_multi  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        if (&lane_same) begin
          if (stable_cnt != DEB_MAX) begin
            stable_cnt <= stable_cnt + SW'(1);
            // Report only on the transition into the debounced state.
            if (stable_cnt == DEB_LAST) begin
              case (hit_cnt)
                2'd1: begin
                  key_code  <= hit_code;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  key_multi <= 1'b0;
                end
                2'd2: begin
                  key_held  <= 1'b0;
                  key_multi <= 1'b1;
                end
                default: begin
                  key_held  <= 1'b0;
                  key_multi <= 1'b0;
                end
              endcase
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (key_held) begin
            if (rep_cnt == RP_LAST) begin
              rep_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
`endif
        end else begin
          stable_cnt <= '0;
          key_held   <= 1'b0;
          key_multi  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt    <= '0;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner; cycle c is sampled #1 after edge c-1 following reset release.
module tb_matrix_keypad_scanner;
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      row_sense;
  logic [3:0]      column_drive;
  logic [3:0]      key_code;
  logic            key_valid, key_held, key_multi;
  logic [3:0][3:0] keys = '0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  matrix_keypad_scanner #(.N_COLS(4), .N_ROWS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
                          .REPEAT_FRAMES(3)) dut (
    .clock(clock), .reset(reset), .row_sense(row_sense), .column_drive(column_drive),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .key_multi(key_multi)
  );

  always #5 clock = ~clock;

  // Physical key matrix: a closed key connects its column strobe to its row line.
  always_comb begin
    row_sense = '0;
    for (int c = 0; c < 4; c++) if (column_drive[c]) row_sense = row_sense | keys[c];
  end

  task automatic step;
    @(posedge clock); #1; cyc++;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    keys = '0;
    do_reset();
    checks++; if (column_drive !== 4'b0001) begin errors++; $display("FAIL rst_col got=%b exp=0001", column_drive); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held got=%b exp=0", key_held); end
    checks++; if (key_multi !== 1'b0) begin errors++; $display("FAIL rst_multi got=%b exp=0", key_multi); end
  endtask

  task automatic test_idle;
    logic [3:0] exp_col;
    keys = '0;
    do_reset();
    while (cyc < 40) begin
      exp_col = 4'b0001 << ((cyc / 4) % 4);
      checks++; if (column_drive !== exp_col) begin errors++; $display("FAIL idle_col cyc=%0d got=%b exp=%b", cyc, column_drive, exp_col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", cyc, key_valid); end
      step();
    end
  endtask

  task automatic test_single_key;
    logic exp_v;
    keys = '0;
    keys[2] = 4'b0010;
    do_reset();
    while (cyc < 100) begin
      exp_v = (cyc == 48) || (REP_EN && cyc == 96);
      checks++; if (key_valid !== exp_v) begin errors++; $display("FAIL key_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (cyc == 48) begin
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL key_code got=%0d exp=9", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL key_held got=%b exp=1", key_held); end
      end
      step();
    end
  endtask

  // Continues from test_single_key at cycle 100.
  task automatic test_release;
    logic exp_v;
    keys = '0;
    while (cyc < 200) begin
      if (cyc == 120) keys[0] = 4'b1000;
      exp_v = (cyc == 176);
      checks++; if (key_valid !== exp_v) begin errors++; $display("FAIL rel_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (cyc == 111) begin
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rel_held_before got=%b exp=1", key_held); end
      end
      if (cyc == 112) begin
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rel_held_after got=%b exp=0", key_held); end
      end
      if (cyc == 176) begin
        checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL rel_code got=%0d exp=3", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rel_held_new got=%b exp=1", key_held); end
      end
      step();
    end
  endtask

  // Continues from test_release at cycle 200 with key_code=3.
  task automatic test_multi;
    keys = '0;
    keys[1] = 4'b0001;
    keys[3] = 4'b0100;
    while (cyc < 272) begin
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_valid cyc=%0d got=%b exp=0", cyc, key_valid); end
      if (cyc == 208) begin
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held_clr got=%b exp=0", key_held); end
      end
      if (cyc == 255) begin
        checks++; if (key_multi !== 1'b0) begin errors++; $display("FAIL multi_early got=%b exp=0", key_multi); end
      end
      if (cyc == 256) begin
        checks++; if (key_multi !== 1'b1) begin errors++; $display("FAIL multi_set got=%b exp=1", key_multi); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held got=%b exp=0", key_held); end
      end
      if (cyc == 271) begin
        checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL multi_code got=%0d exp=3", key_code); end
      end
      step();
    end
  endtask

  task automatic test_bounce;
    logic exp_v;
    keys = '0;
    do_reset();
    while (cyc < 140) begin
      keys[0] = (cyc >= 80 || ((cyc / 16) % 2) == 0) ? 4'b0001 : 4'b0000;
      exp_v = (cyc == 112);
      checks++; if (key_valid !== exp_v) begin errors++; $display("FAIL bounce_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (cyc == 112) begin
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL bounce_code got=%0d exp=0", key_code); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid;
    logic exp_v;
    keys = '0;
    keys[2] = 4'b0010;
    do_reset();
    while (cyc < 40) step();
    reset = 1'b1;
    step();
    checks++; if (column_drive !== 4'b0001) begin errors++; $display("FAIL mid_col got=%b exp=0001", column_drive); end
    checks++; if ({key_valid, key_held, key_multi} !== 3'b000) begin errors++; $display("FAIL mid_flags got=%b exp=000", {key_valid, key_held, key_multi}); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL mid_code got=%0d exp=0", key_code); end
    reset = 1'b0;
    cyc = 0;
    while (cyc < 60) begin
      exp_v = (cyc == 48);
      checks++; if (key_valid !== exp_v) begin errors++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (cyc == 48) begin
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL mid_key_code got=%0d exp=9", key_code); end
      end
      step();
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    logic exp_v;
    keys = '0;
    keys[2] = 4'b0010;
    do_reset();
    while (cyc < 150) begin
      exp_v = (cyc == 48) || (cyc == 96) || (cyc == 144);
      checks++; if (key_valid !== exp_v) begin errors++; $display("FAIL rep_valid cyc=%0d got=%b exp=%b", cyc, key_valid, exp_v); end
      if (exp_v) begin
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL rep_code cyc=%0d got=%0d exp=9", cyc, key_code); end
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single_key();
    test_release();
    test_multi();
    test_bounce();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
